// File: rtl/rectangle128_enc_if.sv
// Block/key-load bus between the RECTANGLE-128 core and its surroundings.
// The master side is the key generator plus the block producer/consumer; the slave side is the core.
interface rectangle128_enc_if #(
    parameter int ADDR_W = 5
);
    logic              flush_mem;
    logic              WE_mem;
    logic [ADDR_W-1:0] WAddr_mem;
    logic [63:0]       KeyIn_mem;
    logic              keys_loaded;
    logic              in_valid;
    logic              in_ready;
    logic [63:0]       in_data;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_data;

    modport master (
        output flush_mem, WE_mem, WAddr_mem, KeyIn_mem, in_valid, in_data, out_ready,
        input  keys_loaded, in_ready, out_valid, out_data
    );

    modport slave (
        input  flush_mem, WE_mem, WAddr_mem, KeyIn_mem, in_valid, in_data, out_ready,
        output keys_loaded, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/rectangle128_enc_core.sv
// Iterative RECTANGLE-128 encryptor: one round per clock over a locally held round-key store.
// state | meaning
// IDLE  | waiting for a plaintext; in_ready when keys are loaded
// ROUND | applying round rnd (0..NUM_ROUNDS-1) to the state register
// OUT   | ciphertext held on out_data until out_ready
module rectangle128_enc_core #(
    parameter int NUM_ROUNDS = 25,
    parameter int ADDR_W     = 5
) (
    input logic               Clk,
    input logic               RstN,
    rectangle128_enc_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_KEY = ADDR_W'(NUM_ROUNDS);
    localparam logic [ADDR_W-1:0] LAST_RND = ADDR_W'(NUM_ROUNDS - 1);
    // S-box entry i lives in bits [4i +: 4]
    localparam logic [63:0] SBOX_TBL = 64'h24F8_D30B_97E1_AC56;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        OUT
    } state_t;

    state_t            fsm;
    logic [ADDR_W-1:0] rnd;
    logic [63:0]       s;
    logic [63:0]       key_mem [0:NUM_ROUNDS];
    logic              keys_loaded;
    logic              in_ready;
    logic              out_valid;
    logic [63:0]       out_data;
    logic [63:0]       rnd_out;

    function automatic logic [63:0] round_fn(input logic [63:0] x);
        logic [15:0] r0, r1, r2, r3;
        logic [3:0]  col;
        r0 = '0;
        r1 = '0;
        r2 = '0;
        r3 = '0;
        for (int j = 0; j < 16; j++) begin
            col   = SBOX_TBL[{x[48+j], x[32+j], x[16+j], x[j], 2'b00} +: 4];
            r0[j] = col[0];
            r1[j] = col[1];
            r2[j] = col[2];
            r3[j] = col[3];
        end
        return {{r3[2:0], r3[15:3]}, {r2[3:0], r2[15:4]}, {r1[14:0], r1[15]}, r0};
    endfunction

    assign rnd_out         = round_fn(s ^ key_mem[rnd]);
    assign in_ready        = (fsm == IDLE) && keys_loaded;
    assign bus.in_ready    = in_ready;
    assign bus.keys_loaded = keys_loaded;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_data;

    always_ff @(posedge Clk) begin
        if (bus.WE_mem && (bus.WAddr_mem <= LAST_KEY)) begin
            key_mem[bus.WAddr_mem] <= bus.KeyIn_mem;
        end
    end

    // Clearing (flush or a restart at key 0) takes priority over completing the set
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            keys_loaded <= 1'b0;
        end else if (bus.flush_mem || (bus.WE_mem && (bus.WAddr_mem == '0))) begin
            keys_loaded <= 1'b0;
        end else if (bus.WE_mem && (bus.WAddr_mem == LAST_KEY)) begin
            keys_loaded <= 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            fsm       <= IDLE;
            rnd       <= '0;
            s         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.in_valid && in_ready) begin
                        s   <= bus.in_data;
                        rnd <= '0;
                        fsm <= ROUND;
                    end
                end
                ROUND: begin
                    s   <= rnd_out;
                    rnd <= rnd + 1'b1;
                    if (rnd == LAST_RND) begin
                        out_data  <= rnd_out ^ key_mem[LAST_KEY];
                        out_valid <= 1'b1;
                        fsm       <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        fsm       <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rectangle128_enc_core.sv
// Directed and random checks of rectangle128_enc_core against an independent RECTANGLE-128 model.
module tb_rectangle128_enc_core;
    logic Clk = 1'b0;
    logic RstN;
    always #5 Clk = ~Clk;

    rectangle128_enc_if #(.ADDR_W(5)) bus ();

    rectangle128_enc_core #(.NUM_ROUNDS(25), .ADDR_W(5)) dut (
        .Clk  (Clk),
        .RstN (RstN),
        .bus  (bus.slave)
    );

    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;
    logic [63:0] keys [26];
    logic [63:0] exp_q [$];
    logic [3:0]  sbox_t [16] = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
                                 4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};

    function automatic logic [63:0] model_enc(input logic [63:0] pt);
        logic [63:0] st;
        logic [15:0] row  [4];
        logic [15:0] nrow [4];
        logic [3:0]  c;
        logic [3:0]  v;
        st = pt;
        for (int r = 0; r < 25; r++) begin
            st = st ^ keys[r];
            for (int b = 0; b < 4; b++) row[b] = st[16*b +: 16];
            for (int j = 0; j < 16; j++) begin
                for (int b = 0; b < 4; b++) c[b] = row[b][j];
                v = sbox_t[c];
                for (int b = 0; b < 4; b++) nrow[b][j] = v[b];
            end
            nrow[1] = (nrow[1] << 1)  | (nrow[1] >> 15);
            nrow[2] = (nrow[2] << 12) | (nrow[2] >> 4);
            nrow[3] = (nrow[3] << 13) | (nrow[3] >> 3);
            st = {nrow[3], nrow[2], nrow[1], nrow[0]};
        end
        return st ^ keys[25];
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic write_key(input logic [4:0] a, input logic [63:0] d, input logic fl);
        bus.WE_mem    = 1'b1;
        bus.WAddr_mem = a;
        bus.KeyIn_mem = d;
        bus.flush_mem = fl;
        tick();
        bus.WE_mem    = 1'b0;
        bus.flush_mem = 1'b0;
        if (int'(a) < 26) keys[a] = d;
    endtask

    // mode 0: all zero, 1: all ones, 2: random
    task automatic load_keys(input int mode);
        logic [63:0] d;
        for (int i = 0; i < 26; i++) begin
            d = (mode == 0) ? 64'h0 : (mode == 1) ? '1 : {$urandom, $urandom};
            if (i == 25) chk1("kl_before_last_key", bus.keys_loaded, 1'b0);
            write_key(5'(i), d, 1'b0);
        end
        chk1("kl_after_last_key", bus.keys_loaded, 1'b1);
        chk1("in_ready_after_load", bus.in_ready, 1'b1);
    endtask

    task automatic send(input logic [63:0] pt);
        int w;
        w            = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = pt;
        while (!bus.in_ready && w < 100) begin
            tick();
            w++;
        end
        chk1("in_ready_wait", bus.in_ready, 1'b1);
        tick();
        exp_q.push_back(model_enc(pt));
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom};
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            tick();
            lat++;
            if (lat == 3) bus.in_data = {$urandom, $urandom};
        end
        chk1("out_valid_wait", bus.out_valid, 1'b1);
    endtask

    task automatic take_out();
        logic [63:0] e;
        chk1("scoreboard_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ciphertext", bus.out_data, e);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk1("out_valid_drop", bus.out_valid, 1'b0);
    endtask

    initial begin
        int lat;
        int stall;
        logic [63:0] held;

        RstN          = 1'b0;
        bus.flush_mem = 1'b0;
        bus.WE_mem    = 1'b0;
        bus.WAddr_mem = '0;
        bus.KeyIn_mem = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk1("rst_keys_loaded", bus.keys_loaded, 1'b0);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 64'h0);
        chk1("rst_in_ready", bus.in_ready, 1'b0);
        RstN = 1'b1;

        // No keys: requests are ignored
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 30; i++) tick();
        chk1("nokey_in_ready", bus.in_ready, 1'b0);
        chk1("nokey_out_valid", bus.out_valid, 1'b0);
        bus.in_valid = 1'b0;

        // All-zero keys and plaintext, with exact latency
        load_keys(0);
        send(64'h0);
        wait_out(lat);
        chk("latency_zero", 64'(lat), 64'd25);
        chk("zero_vector", bus.out_data, 64'h0000_FFFF_FFFF_0000);
        take_out();

        // All-ones keys and plaintext, consumer stalls for 10 cycles
        load_keys(1);
        send('1);
        wait_out(lat);
        chk("latency_ones", 64'(lat), 64'd25);
        chk("ones_vector", bus.out_data, 64'hFFFF_0000_0000_FFFF);
        held = bus.out_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1("stall_out_valid", bus.out_valid, 1'b1);
            chk("stall_out_data", bus.out_data, held);
            chk1("stall_in_ready", bus.in_ready, 1'b0);
        end
        take_out();
        chk1("in_ready_after_take", bus.in_ready, 1'b1);

        // Flush while a result is pending
        load_keys(2);
        send({$urandom, $urandom});
        wait_out(lat);
        bus.flush_mem = 1'b1;
        tick();
        bus.flush_mem = 1'b0;
        chk1("flush_clears_kl", bus.keys_loaded, 1'b0);
        chk1("flush_keeps_valid", bus.out_valid, 1'b1);
        take_out();
        tick();
        chk1("flush_in_ready", bus.in_ready, 1'b0);

        // Reload with flush colliding on the last key, then restart via key 0
        for (int i = 0; i < 25; i++) write_key(5'(i), {$urandom, $urandom}, 1'b0);
        write_key(5'd25, {$urandom, $urandom}, 1'b1);
        chk1("flush_beats_set", bus.keys_loaded, 1'b0);
        write_key(5'd25, {$urandom, $urandom}, 1'b0);
        chk1("set_after_reload", bus.keys_loaded, 1'b1);
        write_key(5'd0, {$urandom, $urandom}, 1'b0);
        chk1("addr0_clears_kl", bus.keys_loaded, 1'b0);
        write_key(5'd25, keys[25], 1'b0);
        chk1("addr25_sets_kl", bus.keys_loaded, 1'b1);
        write_key(5'd27, {$urandom, $urandom}, 1'b0);
        write_key(5'd26, {$urandom, $urandom}, 1'b0);
        chk1("high_addr_keeps_kl", bus.keys_loaded, 1'b1);
        send({$urandom, $urandom});
        wait_out(lat);
        take_out();

        // Reset in the middle of the rounds
        send({$urandom, $urandom});
        for (int i = 0; i < 12; i++) tick();
        RstN = 1'b0;
        #1;
        chk1("midrst_out_valid", bus.out_valid, 1'b0);
        chk1("midrst_in_ready", bus.in_ready, 1'b0);
        chk1("midrst_keys_loaded", bus.keys_loaded, 1'b0);
        chk("midrst_out_data", bus.out_data, 64'h0);
        exp_q.delete();
        tick();
        RstN = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        chk1("postrst_out_valid", bus.out_valid, 1'b0);
        chk1("postrst_in_ready", bus.in_ready, 1'b0);

        // Random blocks against the model
        load_keys(2);
        for (int n = 0; n < 100; n++) begin
            send({$urandom, $urandom});
            wait_out(lat);
            if (lat != 25) chk("rand_latency", 64'(lat), 64'd25);
            stall = $urandom_range(0, 3);
            for (int i = 0; i < stall; i++) tick();
            take_out();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
